conv_mdc_dst_collector: RTL and testbench
=========================================

# conv_mdc_dst_collector

Output collection stage between the `conv_mdc` engine's result stream (`dst_V`) and the streamer's store sink. It buffers engine results in a small first-word-fall-through FIFO and counts accepted words against a programmed job length. It drains the buffer and then pulses `done_o` so the controller can close the job. It also flags any result word the engine produces outside a job window.

## Interface
- `DATA_WIDTH`, 32, width of the result word and of the stream data.
- `FIFO_DEPTH`, 4, number of buffer entries; must be a power of two and at least 2.
- `CNT_WIDTH`, 16, width of the job length and word counter.

- `clk_i` input 1: single clock.
- `rst_i` input 1: reset, asynchronous and active-high.
- `clear_i` input 1: synchronous clear; same effect as reset.
- `start_i` input 1: one-cycle job start pulse.
- `len_i` input CNT_WIDTH: number of words in the job; sampled on `start_i`.
- `in_valid_i` input 1: engine result valid.
- `in_data_i` input DATA_WIDTH: engine result data.
- `in_ready_o` output 1: collector accepts a word.
- `out_valid_o` output 1: word available to the streamer.
- `out_data_o` output DATA_WIDTH: word to the streamer.
- `out_strb_o` output DATA_WIDTH/8: byte strobes, all ones.
- `out_ready_i` input 1: streamer accepts a word.
- `busy_o` output 1: a job is in progress (RUN or DRAIN).
- `done_o` output 1: one-cycle pulse at the end of a job.
- `cnt_o` output CNT_WIDTH: number of words accepted in the current job.
- `err_extra_o` output 1: sticky flag for a word offered outside RUN.
- `stall_cnt_o` output 32: backpressure cycle count (see Configuration).

## Operation
- **States:** IDLE, RUN, DRAIN, DONE. Reset and `clear_i` force IDLE.
- **Reset/clear values:** FIFO empty, counter 0, latched length 0, error flag 0, stall count 0.
- **IDLE:**
  - `in_ready_o` is 0.
  - On `start_i` with `len_i` not 0: latch the length, set `cnt_o` to 0, clear `err_extra_o`, go to RUN.
  - On `start_i` with `len_i` equal to 0: go directly to DONE.
- **RUN:**
  - `in_ready_o` is 1 exactly when the FIFO is not full. Readiness never depends on `out_ready_i`; there is no pass-through when full.
  - Each handshake (`in_valid_i` and `in_ready_o` both high) pushes the word and increments `cnt_o`.
  - When the handshake that makes `cnt_o` equal the latched length occurs, go to DRAIN.
- **DRAIN:** `in_ready_o` is 0. Go to DONE in the cycle after the FIFO becomes empty.
- **DONE:** `done_o` is 1 for exactly one cycle, then go to IDLE. `cnt_o` holds its final value until the next start.
- **Outputs to the streamer:**
  - `out_valid_o` is 1 whenever the FIFO is not empty, in any state.
  - A pop happens on `out_valid_o` and `out_ready_i` both high.
  - `out_data_o` is the FIFO head. It must stay stable while `out_valid_o` is high and `out_ready_i` is low.
- **FIFO boundaries:**
  - A simultaneous push and pop with the FIFO neither full nor empty leaves the occupancy unchanged.
  - A push into an empty FIFO together with a pop is impossible, because `out_valid_o` is 0 when empty.
  - Pointers are log2(FIFO_DEPTH) wide plus one wrap bit and wrap modulo FIFO_DEPTH.
- **Error flag:** `in_valid_i` high while in IDLE, DRAIN or DONE sets `err_extra_o`. The word is not accepted. The flag stays set until the next `start_i`, `clear_i` or reset.
- **`start_i` outside IDLE:** ignored; it does not affect the error flag.
- **`busy_o`:** 1 in RUN and DRAIN.
- **Counter width:** `cnt_o` does not wrap, because RUN ends at the latched length, which is at most 2^CNT_WIDTH-1.

## Timing
- **Latency:** a word accepted at clock edge N is visible on `out_data_o` with `out_valid_o` high after edge N (one cycle).
- **Throughput:** one word per cycle sustained when `out_ready_i` is held at 1.
- **Job end:** `done_o` rises two cycles after the last pop edge (one cycle for the empty detection, then the DONE cycle).
- **Zero length:** `done_o` is high in the cycle after the `start_i` cycle.
- **Reset mid-job:** asserting `rst_i` asynchronously empties the FIFO and forces IDLE; buffered words are lost. `clear_i` has the same effect at the next edge.
- **Start in the DONE cycle:** `start_i` asserted while in DONE is ignored.

## Configuration
- **`CONV_MDC_COLLECTOR_PERF_EN` defined:** `stall_cnt_o` counts cycles with `busy_o` high, `out_valid_o` high and `out_ready_i` low.
  - The count saturates at 2^32-1.
  - It is cleared on `start_i` accepted in IDLE, on `clear_i` and on reset.
- **Macro not defined:** `stall_cnt_o` is tied to 0 and no counter logic is built.

## Test plan
- Start with `len_i`=8, `in_valid_i` held at 1, `out_ready_i` held at 1, data 0..7.
  - Required: the streamer receives 0..7 in order at one word per cycle.
  - Required: `cnt_o`=8 and a single `done_o` pulse two cycles after the last pop.
- `len_i`=6, `out_ready_i`=0 for the first 10 cycles.
  - Required: `in_ready_o` drops after 4 accepts; `out_data_o` holds word 0 throughout the stall.
  - Required: after release, all 6 words arrive; with the macro defined, `stall_cnt_o` is 9 (stall counted from the first cycle `out_valid_o` is high).
- `start_i` with `len_i`=0.
  - Required: `done_o` is high in the next cycle, `busy_o` stays 0 and there is no streamer traffic.
- `in_valid_i`=1 while in IDLE.
  - Required: `err_extra_o` becomes 1 and `in_ready_o` stays 0.
  - Required: the next `start_i` clears `err_extra_o`.
- `len_i`=4, assert `rst_i` after 2 accepts with `out_ready_i`=0.
  - Required: `out_valid_o`, `busy_o` and `cnt_o` are 0 immediately; no `done_o` pulse.
- Random `in_valid_i` and `out_ready_i` over a job with `len_i`=100, repeated for FIFO_DEPTH of 2 and 8.
  - Required: output order and data match input, with no loss or duplication.
  - Required: exactly one `done_o` pulse.

Source files
------------

// File: rtl/conv_mdc_dst_collector.sv
// conv_mdc_dst_collector: buffers conv_mdc results in a FWFT FIFO, counts a job and pulses done after drain.
// Optional stall counter built when CONV_MDC_COLLECTOR_PERF_EN is defined.
module conv_mdc_dst_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [CNT_WIDTH-1:0]    len_i,
  input  logic                    in_valid_i,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic [DATA_WIDTH/8-1:0] out_strb_o,
  input  logic                    out_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_WIDTH-1:0]    cnt_o,
  output logic                    err_extra_o,
  output logic [31:0]             stall_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;

  logic [1:0]            state, state_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]  len_q, cnt;
  logic                  err, full, empty, push, pop, start_ok;

  assign empty       = wr_ptr == rd_ptr;
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready_o  = (state == RUN) && !full;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = !empty && out_ready_i;
  assign start_ok    = (state == IDLE) && start_i;
  assign out_valid_o = !empty;
  assign out_data_o  = mem[rd_ptr[AW-1:0]];
  assign out_strb_o  = '1;
  assign busy_o      = (state == RUN) || (state == DRAIN);
  assign done_o      = state == DONE;
  assign cnt_o       = cnt;
  assign err_extra_o = err;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : RUN;
      RUN:     if (push && CNT_WIDTH'(cnt + 1'b1) == len_q) state_d = DRAIN;
      DRAIN:   if (empty) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      len_q  <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else if (clear_i) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      len_q  <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (start_ok) len_q <= len_i;
      if (push) cnt <= cnt + 1'b1;
      else if (start_ok) cnt <= '0;
      err <= start_ok ? 1'b0 : (err | (in_valid_i && state != RUN));
    end
  end

  // storage needs no reset: occupancy is defined by the pointers alone
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data_i;
  end

`ifdef CONV_MDC_COLLECTOR_PERF_EN
  logic [31:0] stall;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall <= '0;
    else if (clear_i || start_ok) stall <= '0;
    else if (busy_o && out_valid_o && !out_ready_i && stall != '1) stall <= stall + 1'b1;
  end
  assign stall_cnt_o = stall;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_conv_mdc_dst_collector.sv
// tb_conv_mdc_dst_collector: directed and randomized checks of the collector at FIFO depths 4, 2 and 8.
module tb_conv_mdc_dst_collector;
  localparam int DW = 32, CW = 16, NI = 3, RLEN = 100;

  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, start = 1'b0;
  logic [CW-1:0] len = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [NI-1:0] in_ready, out_valid, busy, done, err;
  logic [DW-1:0] out_data [NI];
  logic [3:0]    strb [NI];
  logic [CW-1:0] cnt [NI];
  logic [31:0]   stall [NI];
  int n_vec = 0, n_err = 0;

  function automatic int dep(input int k);
    return k == 0 ? 4 : (k == 1 ? 2 : 8);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    conv_mdc_dst_collector #(.DATA_WIDTH(DW), .FIFO_DEPTH(g == 0 ? 4 : (g == 1 ? 2 : 8)), .CNT_WIDTH(CW)) dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .len_i(len),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready[g]),
      .out_valid_o(out_valid[g]), .out_data_o(out_data[g]), .out_strb_o(strb[g]),
      .out_ready_i(out_ready), .busy_o(busy[g]), .done_o(done[g]), .cnt_o(cnt[g]),
      .err_extra_o(err[g]), .stall_cnt_o(stall[g]));
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  // one job on the depth-4 instance: words 0..n-1, streamer stalled for the first `hold` cycles
  task automatic job(input int n, input int hold, input int exp_stall);
    int acc, rx, last_pop, dones, i;
    logic pu, po;
    clr();
    acc = 0; rx = 0; last_pop = -100; dones = 0;
    start = 1'b1; len = CW'(n);
    cyc();
    start = 1'b0;
    for (i = 0; i < 80 && dones == 0; i++) begin
      out_ready = i >= hold;
      in_valid = acc < n;
      in_data = acc;
      #1;
      pu = in_valid && acc < n && (acc - rx) < 4;
      po = acc > rx && out_ready;
      chk("job_rdy", in_ready[0], acc < n && (acc - rx) < 4);
      chk("job_vld", out_valid[0], acc > rx);
      if (acc > rx) chk("job_data", out_data[0], rx);
      if (done[0]) begin
        dones++;
        chk("job_done_lat", i - last_pop, 2);
      end
      if (pu) acc++;
      if (po) begin rx++; last_pop = i; end
      cyc();
    end
    in_valid = 1'b0;
    chk("job_done_seen", dones, 1);
    chk("job_cnt", cnt[0], n);
    chk("job_rx", rx, n);
    for (int j = 0; j < 3; j++) begin
      chk("job_no_2nd_done", done[0], 0);
      chk("job_idle_busy", busy[0], 0);
      cyc();
    end
    chk("job_cnt_hold", cnt[0], n);
`ifdef CONV_MDC_COLLECTOR_PERF_EN
    chk("job_stall", stall[0], exp_stall);
`else
    chk("job_stall", stall[0], 0 * exp_stall);
`endif
  endtask

  initial begin
    int acc[NI], hd[NI], ph[NI], dn[NI], st[NI], d;
    logic [31:0] mq [NI][128];
    logic errm[NI], run, er, ov, fin;
    @(negedge clk);
    chk("rst_vld", out_valid[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_cnt", cnt[0], 0);
    chk("rst_err", err[0], 0);
    chk("rst_rdy", in_ready[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_stall", stall[0], 0);
    chk("strb", strb[0], 4'hf);
    rst = 1'b0;
    cyc();

    job(8, 0, 0);
    job(6, 10, 9);

    clr();
    start = 1'b1; len = '0;
    #1 chk("zl_busy0", busy[0], 0);
    cyc();
    start = 1'b0;
    chk("zl_done", done[0], 1);
    chk("zl_busy", busy[0], 0);
    chk("zl_vld", out_valid[0], 0);
    cyc();
    chk("zl_done_off", done[0], 0);
    chk("zl_busy2", busy[0], 0);

    clr();
    in_valid = 1'b1; in_data = 32'hdead;
    #1 chk("idle_rdy", in_ready[0], 0);
    cyc();
    in_valid = 1'b0;
    chk("idle_err", err[0], 1);
    chk("idle_vld", out_valid[0], 0);
    start = 1'b1; len = 16'd3;
    cyc();
    start = 1'b0;
    chk("start_clr_err", err[0], 0);
    chk("start_busy", busy[0], 1);

    clr();
    start = 1'b1; len = 16'd4;
    cyc();
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = 32'h11;
    cyc();
    in_data = 32'h22;
    cyc();
    in_valid = 1'b0;
    #1;
    chk("pre_rst_cnt", cnt[0], 2);
    chk("pre_rst_vld", out_valid[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", out_valid[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_cnt", cnt[0], 0);
    cyc();
    rst = 1'b0;
    d = 0;
    for (int j = 0; j < 6; j++) begin
      d += int'(done[0]);
      cyc();
    end
    chk("arst_no_done", d, 0);

    clr();
    start = 1'b1; len = CW'(RLEN); in_valid = 1'b0; out_ready = 1'b0;
    cyc();
    start = 1'b0;
    for (int k = 0; k < NI; k++) begin
      acc[k] = 0; hd[k] = 0; ph[k] = 0; dn[k] = 0; st[k] = 0; errm[k] = 1'b0;
    end
    fin = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_data = $urandom;
      #1;
      fin = 1'b1;
      for (int k = 0; k < NI; k++) begin
        run = ph[k] == 0 && acc[k] < RLEN;
        er = run && (acc[k] - hd[k]) < dep(k);
        ov = acc[k] > hd[k];
        chk("rnd_rdy", in_ready[k], er);
        chk("rnd_vld", out_valid[k], ov);
        if (ov) chk("rnd_data", out_data[k], mq[k][hd[k]]);
        chk("rnd_busy", busy[k], ph[k] <= 1);
        chk("rnd_done", done[k], ph[k] == 2);
        chk("rnd_cnt", cnt[k], acc[k]);
        chk("rnd_err", err[k], errm[k]);
`ifdef CONV_MDC_COLLECTOR_PERF_EN
        chk("rnd_stall", stall[k], st[k]);
`else
        chk("rnd_stall", stall[k], 0);
`endif
        if (done[k]) dn[k]++;
        errm[k] = errm[k] | (in_valid && !run);
        if (ph[k] <= 1 && ov && !out_ready) st[k]++;
        if (in_valid && er) begin mq[k][acc[k]] = in_data; acc[k]++; end
        if (ov && out_ready) hd[k]++;
        if (ph[k] == 0) ph[k] = (acc[k] == RLEN && hd[k] == acc[k]) ? 1 : 0;
        else if (ph[k] < 3) ph[k]++;
        if (ph[k] != 3) fin = 1'b0;
      end
      cyc();
    end
    in_valid = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk("rnd_finished", ph[k], 3);
      chk("rnd_final_cnt", cnt[k], RLEN);
      chk("rnd_popped", hd[k], RLEN);
      chk("rnd_one_done", dn[k], 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
